// File: rtl/mult_sched_if.sv
// Bundle of requester and core-side signals for the shared multiplier scheduler.
// The scheduler uses the slave view; whatever drives the requesters and the core uses the master view.
interface mult_sched_if;
  logic        req0;
  logic        req1;
  logic [7:0]  a0;
  logic [7:0]  b0;
  logic [7:0]  a1;
  logic [7:0]  b1;
  logic        ack0;
  logic        ack1;
  logic [15:0] res;
  logic        err;
  logic        busy;
  logic [7:0]  core_a;
  logic [7:0]  core_b;
  logic        core_start;
  logic [15:0] core_r;
  logic        core_done;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, core_r, core_done,
    output ack0, ack1, res, err, busy, core_a, core_b, core_start
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, core_r, core_done,
    input  ack0, ack1, res, err, busy, core_a, core_b, core_start
  );
endinterface

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one multiplier core between two requesters,
// with zero-operand short-cut and a WAIT-state timeout.
module mult_sched #(
  parameter int TIMEOUT = 300
) (
  input  logic          clk,
  input  logic          rst,
  mult_sched_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [15:0] LP_LAST_CNT = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_grant;
  logic        r_last;
  logic [15:0] r_cnt;
  logic        r_ack0;
  logic        r_ack1;
  logic [15:0] r_res;
  logic        r_err;
  logic        r_busy;
  logic        r_start;
  logic [7:0]  r_core_a;
  logic [7:0]  r_core_b;

  logic        w_any;
  logic        w_win;
  logic [7:0]  w_a;
  logic [7:0]  w_b;

  // On a tie the requester that was not served last takes the grant.
  assign w_any = bus.req0 | bus.req1;
  assign w_win = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
  assign w_a   = w_win ? bus.a1 : bus.a0;
  assign w_b   = w_win ? bus.b1 : bus.b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_grant  <= 1'b0;
      r_last   <= 1'b1;
      r_cnt    <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_res    <= '0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_start  <= 1'b0;
      r_core_a <= '0;
      r_core_b <= '0;
    end else begin
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant  <= w_win;
            r_core_a <= w_a;
            r_core_b <= w_b;
            r_busy   <= 1'b1;
            if (w_a == 8'd0 || w_b == 8'd0) begin
              r_res   <= '0;
              r_err   <= 1'b0;
              r_ack0  <= ~w_win;
              r_ack1  <= w_win;
              r_state <= RESP;
            end else begin
              r_start <= 1'b1;
              r_state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          // Done outranks a timeout firing on the same edge.
          if (bus.core_done) begin
            r_res   <= bus.core_r;
            r_err   <= 1'b0;
            r_ack0  <= ~r_grant;
            r_ack1  <= r_grant;
            r_state <= RESP;
          end else if (r_cnt == LP_LAST_CNT) begin
            r_res   <= '0;
            r_err   <= 1'b1;
            r_ack0  <= ~r_grant;
            r_ack1  <= r_grant;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RESP: begin
          r_last  <= r_grant;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack0       = r_ack0;
  assign bus.ack1       = r_ack1;
  assign bus.res        = r_res;
  assign bus.err        = r_err;
  assign bus.busy       = r_busy;
  assign bus.core_a     = r_core_a;
  assign bus.core_b     = r_core_b;
  assign bus.core_start = r_start;

endmodule

// File: tb/tb_mult_sched.sv
// Directed bench for mult_sched: one instance with a sticky-done model core,
// a second instance with TIMEOUT = 8 for the timeout path.
module tb_mult_sched;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   lat;

  mult_sched_if m_if ();
  mult_sched_if t_if ();

  mult_sched #(.TIMEOUT(300)) u_dut (.clk(clk), .rst(rst), .bus(m_if.slave));
  mult_sched #(.TIMEOUT(8))   u_to  (.clk(clk), .rst(rst), .bus(t_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model core: restarts on core_start, raises a sticky done so that it is
  // sampled high 'lat' edges after the start edge.
  logic        m_run;
  int          m_cnt;
  logic        m_done;
  logic [15:0] m_prod;
  logic [15:0] m_r;

  initial begin
    m_run  = 1'b0;
    m_cnt  = 0;
    m_done = 1'b0;
    m_prod = '0;
    m_r    = '0;
  end

  always @(posedge clk) begin
    if (m_if.core_start) begin
      m_run  <= 1'b1;
      m_cnt  <= 2;
      m_done <= 1'b0;
      m_prod <= 16'(m_if.core_a) * 16'(m_if.core_b);
    end else if (m_run) begin
      if (m_cnt == lat - 1) begin
        m_done <= 1'b1;
        m_r    <= m_prod;
        m_run  <= 1'b0;
      end
      m_cnt <= m_cnt + 1;
    end
  end

  assign m_if.core_done = m_done;
  assign m_if.core_r    = m_r;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Steps through the decision edge and waits for an ack; who = {ack1,ack0}.
  task automatic wait_ack(input bit sel, input int max_cyc,
                          output int cyc, output int nstart, output int who);
    logic a0, a1, st;
    cyc = 0;
    nstart = 0;
    who = 0;
    tick();
    cyc = 1;
    while (cyc <= max_cyc) begin
      a0 = sel ? t_if.ack0 : m_if.ack0;
      a1 = sel ? t_if.ack1 : m_if.ack1;
      st = sel ? t_if.core_start : m_if.core_start;
      if (st) nstart++;
      if (a0 || a1) begin
        who = {30'd0, a1, a0};
        break;
      end
      tick();
      cyc++;
    end
    $display("ack wait: dut=%0d cycles=%0d who=%0d starts=%0d", sel, cyc, who, nstart);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, ns, who;
    n_cmp = 0;
    n_err = 0;
    lat   = 10;
    rst   = 1'b1;
    m_if.req0 = 1'b0; m_if.req1 = 1'b0;
    m_if.a0 = '0; m_if.b0 = '0; m_if.a1 = '0; m_if.b1 = '0;
    t_if.req0 = 1'b0; t_if.req1 = 1'b0;
    t_if.a0 = '0; t_if.b0 = '0; t_if.a1 = '0; t_if.b1 = '0;
    t_if.core_done = 1'b0; t_if.core_r = '0;
    repeat (3) tick();

    check("rst_ack",   {m_if.ack1, m_if.ack0}, 0);
    check("rst_res",   m_if.res, 0);
    check("rst_err",   m_if.err, 0);
    check("rst_busy",  m_if.busy, 0);
    check("rst_start", m_if.core_start, 0);
    check("rst_core_ab", {m_if.core_a, m_if.core_b}, 0);
    rst = 1'b0;

    // Single core job, done after 10 cycles.
    m_if.a0 = 8'd12; m_if.b0 = 8'd10; m_if.req0 = 1'b1;
    wait_ack(0, 40, cyc, ns, who);
    check("t1_lat", cyc, 11);
    check("t1_who", who, 1);
    check("t1_starts", ns, 1);
    check("t1_res", m_if.res, 120);
    check("t1_err", m_if.err, 0);
    m_if.req0 = 1'b0;
    tick();
    check("t1_ack_single", {m_if.ack1, m_if.ack0}, 0);
    check("t1_busy_idle", m_if.busy, 0);

    // Both requesters held: grants alternate starting with 0 after reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lat = 3;
    m_if.a0 = 8'd3; m_if.b0 = 8'd4; m_if.a1 = 8'd3; m_if.b1 = 8'd4;
    m_if.req0 = 1'b1; m_if.req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(0, 20, cyc, ns, who);
      check("t2_who", who, (k % 2 == 0) ? 1 : 2);
      check("t2_lat", cyc, 4);
      check("t2_res", m_if.res, 12);
      tick();
      check("t2_ack_single", {m_if.ack1, m_if.ack0}, 0);
    end
    m_if.req0 = 1'b0; m_if.req1 = 1'b0;

    // Zero operand is answered without the core.
    m_if.a1 = 8'd0; m_if.b1 = 8'd200; m_if.req1 = 1'b1;
    wait_ack(0, 10, cyc, ns, who);
    check("t3_lat", cyc, 1);
    check("t3_who", who, 2);
    check("t3_res", m_if.res, 0);
    check("t3_err", m_if.err, 0);
    check("t3_starts", ns, 0);
    m_if.req1 = 1'b0;
    tick();

    // Timeout instance: core never completes.
    t_if.a0 = 8'd5; t_if.b0 = 8'd6; t_if.req0 = 1'b1;
    wait_ack(1, 30, cyc, ns, who);
    check("t4_lat", cyc, 10);
    check("t4_who", who, 1);
    check("t4_err", t_if.err, 1);
    check("t4_res", t_if.res, 0);
    t_if.req0 = 1'b0;
    tick();
    t_if.a0 = 8'd7; t_if.b0 = 8'd9; t_if.req0 = 1'b1;
    tick();
    check("t4b_start", t_if.core_start, 1);
    check("t4b_core_a", t_if.core_a, 7);
    tick();
    t_if.core_r = 16'd63; t_if.core_done = 1'b1;
    tick();
    check("t4b_ack", {t_if.ack1, t_if.ack0}, 1);
    check("t4b_res", t_if.res, 63);
    check("t4b_err", t_if.err, 0);
    t_if.req0 = 1'b0; t_if.core_done = 1'b0;
    tick();

    // Stale sticky done (holding 12) must not complete the new job.
    lat = 4;
    m_if.a0 = 8'd255; m_if.b0 = 8'd255; m_if.req0 = 1'b1;
    wait_ack(0, 20, cyc, ns, who);
    check("t5_lat", cyc, 5);
    check("t5_who", who, 1);
    check("t5_res", m_if.res, 65025);
    m_if.req0 = 1'b0;
    tick();

    // Reset during WAIT: no ack, request held through reset is re-served.
    lat = 20;
    m_if.a0 = 8'd2; m_if.b0 = 8'd3; m_if.req0 = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("t6_busy", m_if.busy, 0);
    check("t6_start", m_if.core_start, 0);
    check("t6_ack", {m_if.ack1, m_if.ack0}, 0);
    rst = 1'b0;
    wait_ack(0, 40, cyc, ns, who);
    check("t6_lat", cyc, 21);
    check("t6_who", who, 1);
    check("t6_res", m_if.res, 6);
    m_if.req0 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_sched.md
# mult_sched

Two-requester scheduler that shares one 8x8 repeated-addition multiplier core between two clients. It arbitrates round-robin and latches the winner's operands. It then launches the core with a start pulse, waits for its done signal (with a cycle-limit timeout), and returns the 16-bit product to the granted requester with a one-cycle acknowledge. Zero operands are answered directly without using the core.

## Interface
- TIMEOUT, 300: maximum WAIT cycles before the job is aborted with an error. Must be ≥ 2 and ≤ 65535.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  request level. Held with operands stable until the matching ack.
- a0, b0 / a1, b1  in  8 each  operands of requester 0 / 1
- ack0 / ack1  out  1  one-cycle acknowledge. res/err are valid in this cycle.
- res  out  16  product, shared by both requesters
- err  out  1  job timed out; res = 0
- busy  out  1  high in every state except IDLE
- core_a, core_b  out  8 each  operands to the core, held constant from ISSUE through WAIT
- core_start  out  1  one-cycle launch pulse
- core_r  in  16  core result, sampled when core_done = 1 in WAIT
- core_done  in  1  core completion flag (level or pulse)

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Arbitration in IDLE:
  - Only one request present: that requester wins.
  - Both present: the requester not granted last wins.
  - The last-granted register resets to 1, so requester 0 wins the first tie.
  - The last-granted register updates only in RESP.
- IDLE with a winner:
  - Latch the winner's a and b into core_a/core_b and record the grant index.
  - If a == 0 or b == 0: go to RESP with res = 0, err = 0. The core is never started.
  - Otherwise: go to ISSUE.
- ISSUE:
  - core_start = 1 for exactly this cycle.
  - Clear the timeout counter (16-bit).
  - Go to WAIT.
- WAIT:
  - If core_done = 1: res <= core_r, err <= 0, go to RESP.
  - Otherwise, counter increments. When counter == TIMEOUT-1 and core_done = 0: res <= 0, err <= 1, go to RESP.
  - If core_done arrives in the same cycle the timeout would fire, done wins.
- RESP:
  - Assert ack of the granted requester only; the other ack stays 0.
  - Update last-granted, go to IDLE.
- core_done is ignored in IDLE, ISSUE and RESP, so a stale sticky done from a previous job cannot complete a new one.
- Width rule: the 8x8 product fits in 16 bits (max 255*255 = 65025). res is passed through unmodified.
- Requests are never queued; a request with req low at the IDLE decision edge is not seen.

## Timing
- Reset values: ack0 = ack1 = 0, res = 0, err = 0, busy = 0, core_start = 0, core_a = core_b = 0, last-granted = 1, counter = 0.
- Reset asserted in any state:
  - Next state is IDLE; all outputs take their reset values.
  - No ack is issued for the in-flight job.
  - Pending requests are re-arbitrated normally once rst is low.
- Zero-operand latency: req sampled at edge E0 -> ack high in the cycle after E0 (1 cycle).
- Core job latency:
  - Edge E0: IDLE -> ISSUE. core_start is high between E0 and E1.
  - Edge E1: ISSUE -> WAIT.
  - core_done sampled high at edge En (n ≥ 2): ack is high in the cycle after En.
  - Total = n + 1 cycles.
- Timeout latency: ack with err = 1 is high exactly TIMEOUT + 2 cycles after E0.
- Back-to-back:
  - A requester that keeps req high after its ack is treated as issuing a new request.
  - The earliest next grant is at the edge after RESP (IDLE decision).
  - With both requesters held high, grants alternate 0, 1, 0, 1, …
- core_a/core_b do not change between ISSUE and leaving WAIT, even if a0/b0/a1/b1 change.

## Test plan
- Reset then req0 with a0 = 12, b0 = 10, and a model core giving done after 10 cycles -> one core_start pulse; ack0 with res = 120, err = 0, 11 cycles after grant; ack1 stays 0.
- req0 and req1 asserted together and held, a = 3, b = 4 for both -> acks alternate ack0, ack1, ack0, ack1; each res = 12; every ack is a single cycle.
- req1 with a1 = 0, b1 = 200 -> ack1 one cycle after the decision edge; res = 0; core_start never pulses.
- TIMEOUT = 8, core never asserts done -> ack0 with err = 1, res = 0, 10 cycles after the decision edge; the next request proceeds normally.
- core_done held high from the previous job, new request a = 255, b = 255 -> done not accepted before WAIT; res = 65025.
- rst asserted during WAIT -> no ack; busy = 0 and core_start = 0 on the next cycle; a request held through reset is served after release.
